age_issue_queue: RTL and testbench
==================================

// Module: age_issue_queue
// PURPOSE
//  Parametrised integer issue queue: DEPTH entries, ENQ_W dispatch ports, ISS_W issue ports, 2 sources per uop.
//  Tracks operand readiness via the wakeup bus and picks the oldest ready entries with an age matrix.
//  Flushes wrong-path entries on backend redirect.
//  Sits between dispatch and the register-read/ALU stage.
// PARAMETERS
//  DEPTH     16  entry count (power of 2, >= ENQ_W)
//  ENQ_W      2  dispatch ports per cycle
//  ISS_W      2  issue ports per cycle (1..4)
//  WK_W       4  wakeup bus ports
//  DATA_W    64  opaque payload width (uop bundle)
//  PREG_W     7  physical register tag width
//  ROB_W      6  ROB index width; bit ROB_W is the wrap flag
// PORTS
//  clk            in   1                clock
//  rst            in   1                asynchronous reset, active-high
//  enq_en         in   ENQ_W            dispatch request per port
//  enq_data       in   ENQ_W*DATA_W     payload
//  enq_rob        in   ENQ_W*(ROB_W+1)  ROB index + wrap flag
//  enq_src        in   ENQ_W*2*PREG_W   source tags
//  enq_src_rdy    in   ENQ_W*2          source already ready at dispatch
//  enq_ready      out  1                all ENQ_W ports may write this cycle
//  free_cnt       out  $clog2(DEPTH)+1  free entries (registered)
//  wk_en          in   WK_W             wakeup valid
//  wk_preg        in   WK_W*PREG_W      wakeup destination tag
//  iss_valid      out  ISS_W            issue candidate valid
//  iss_ready      in   ISS_W            reg-read/FU accepts port k
//  iss_data       out  ISS_W*DATA_W     payload of selected entry
//  iss_rob        out  ISS_W*(ROB_W+1)  ROB index of selected entry
//  iss_src        out  ISS_W*2*PREG_W   source tags for register read
//  redirect       in   1                backend redirect
//  redirect_idx   in   ROB_W+1          redirecting ROB index
// BEHAVIOUR
//  - Reset (async, rst=1): all entries invalid; age matrix cleared.
//    free_cnt=DEPTH, enq_ready=1, iss_valid=0.
//  - Enqueue is all-or-nothing.
//    enq_ready = (free_cnt >= ENQ_W) & ~redirect.
//    Port i writes at the edge only if enq_en[i] & enq_ready.
//    Entries are allocated lowest-free-index first, port 0 first.
//    enq_en while ~enq_ready is dropped; dispatch must hold it.
//  - Age: on write, the new entry is younger than every valid entry.
//    Among same-cycle writes, the lower port is older.
//  - Wakeup: src_rdy is set at the edge when wk_en[j] & wk_preg[j]==src tag.
//    Also applies to an entry being enqueued the same cycle (enq_src compared to wk_preg).
//  - Select (combinational): cand = valid & both src_rdy & ~flushed_now.
//    Port 0 takes the oldest cand; port k takes the oldest of cand minus ports 0..k-1.
//    iss_valid[k]=0 if fewer than k+1 cands.
//  - Dequeue: entry freed at the edge when iss_valid[k] & iss_ready[k].
//    If not accepted, the entry stays and may be re-selected next cycle.
//    Issue latency 1 cycle min: enqueue at t with both srcs ready -> iss_valid at t+1.
//  - Redirect: an entry is flushed when its rob is younger than redirect_idx.
//    Compare: flag equal -> idx > redirect_idx; flag differs -> idx < redirect_idx.
//    During the redirect cycle, flushed entries are masked from iss_valid and invalidated at the edge.
//    Redirect-cycle enqueues are blocked.
//  - free_cnt is registered: DEPTH - popcount(next valid).
//    Covers simultaneous enq, issue and flush; never under/overflows.
//  - Full: free_cnt < ENQ_W -> enq_ready=0 even with free entries; issue continues.
//  - Empty: iss_valid=0; wakeups are ignored.
// CONFIGURATION
//  IQ_BYPASS_WAKEUP_EN defined:
//    wk_en/wk_preg in cycle t also feed the readiness used by select in t.
//    An entry waiting only on that tag issues in t.
//  Undefined:
//    wakeup takes effect at the edge; earliest issue is t+1.
// TESTING
//  - Reset, then enq 2 uops with all srcs ready, iss_ready=11 -> next cycle iss_valid=11, port0=older.
//  - Fill 16 entries with src tag 9 not ready -> enq_ready=0, free_cnt=0.
//    wk_preg=9 at t -> iss at t+1 (t with BYPASS); free_cnt reaches 2 two cycles later.
//  - Uops with rob 3,4,5 (flag 0) all ready, ISS_W=2, iss_ready=01 -> rob 3 issues.
//    rob 4 and 5 stay; next cycle port0=rob 4.
//  - Entries rob 62,63 (flag 0) and 0,1 (flag 1); redirect_idx=63/flag0 -> rob 0 and 1 flushed.
//    iss_valid never shows them; free_cnt +2.
//  - Enq with tag 12 while wk_preg=12 same cycle -> entry ready.
//    iss_valid next cycle with no further wakeup.
//  - Assert rst mid-stream with 5 valid entries -> iss_valid=0 immediately, free_cnt=16.

Source files
------------

// File: rtl/age_issue_queue.sv
// age_issue_queue: out-of-order integer issue queue with age-matrix oldest-ready select.
// Latency: enqueue at t with both sources ready -> iss_valid at t+1. With IQ_BYPASS_WAKEUP_EN, a
//   same-cycle wakeup also feeds select.
// Backpressure: enq_ready is all-or-nothing and a dropped enq_en must be held by dispatch. An entry not
//   taken by iss_ready stays and is re-selected.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   enq_en/data/rob/src/src_rdy  ENQ_W dispatch ports; enq_ready grants all of them together
//   free_cnt                     registered count of free entries
//   wk_en/wk_preg                WK_W wakeup ports (destination physical tags)
//   iss_valid/ready/data/rob/src ISS_W issue ports, port 0 carries the oldest candidate
//   redirect/redirect_idx        flush every entry younger than redirect_idx (ROB index + wrap flag)
//
// Optional feature macro: IQ_BYPASS_WAKEUP_EN (same-cycle wakeup-to-select bypass).
module age_issue_queue #(
  parameter int DEPTH  = 16,
  parameter int ENQ_W  = 2,
  parameter int ISS_W  = 2,
  parameter int WK_W   = 4,
  parameter int DATA_W = 64,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ENQ_W-1:0]              enq_en,
  input  logic [ENQ_W*DATA_W-1:0]       enq_data,
  input  logic [ENQ_W*(ROB_W+1)-1:0]    enq_rob,
  input  logic [ENQ_W*2*PREG_W-1:0]     enq_src,
  input  logic [ENQ_W*2-1:0]            enq_src_rdy,
  output logic                          enq_ready,
  output logic [$clog2(DEPTH):0]        free_cnt,
  input  logic [WK_W-1:0]               wk_en,
  input  logic [WK_W*PREG_W-1:0]        wk_preg,
  output logic [ISS_W-1:0]              iss_valid,
  input  logic [ISS_W-1:0]              iss_ready,
  output logic [ISS_W*DATA_W-1:0]       iss_data,
  output logic [ISS_W*(ROB_W+1)-1:0]    iss_rob,
  output logic [ISS_W*2*PREG_W-1:0]     iss_src,
  input  logic                          redirect,
  input  logic [ROB_W:0]                redirect_idx
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry state
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_rdy0;
  logic [DEPTH-1:0]  r_rdy1;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ROB_W:0]    r_rob  [DEPTH];
  logic [PREG_W-1:0] r_src0 [DEPTH];
  logic [PREG_W-1:0] r_src1 [DEPTH];
  // r_age[i][j] = 1 means entry i is older than entry j (meaningful only when both are valid)
  logic [DEPTH-1:0]  r_age  [DEPTH];
  logic [CNT_W-1:0]  r_free_cnt;

  logic [DEPTH-1:0]   w_hit0, w_hit1;
  logic [ENQ_W*2-1:0] w_enq_hit;
  logic [DEPTH-1:0]   w_flush;
  logic [DEPTH-1:0]   w_rdy0_eff, w_rdy1_eff;
  logic [DEPTH-1:0]   w_cand;
  logic [DEPTH-1:0]   w_sel [ISS_W];
  logic [DEPTH-1:0]   w_deq;
  logic [ENQ_W-1:0]   w_wr_vld;
  logic [IDX_W-1:0]   w_wr_idx [ENQ_W];
  logic [DEPTH-1:0]   w_wr_mask;
  logic [DEPTH-1:0]   w_valid_nxt;
  logic [CNT_W-1:0]   w_pop;
  logic [DEPTH-1:0]   w_age_nxt [DEPTH];

  // ROB order across the wrap: same flag compares indices directly, differing flag inverts the sense.
  function automatic logic rob_younger(input logic [ROB_W:0] a, input logic [ROB_W:0] b);
    if (a[ROB_W] == b[ROB_W]) return a[ROB_W-1:0] > b[ROB_W-1:0];
    else                      return a[ROB_W-1:0] < b[ROB_W-1:0];
  endfunction

  // Wakeup tag matches against resident entries and against sources being dispatched this cycle
  always_comb begin
    w_hit0    = '0;
    w_hit1    = '0;
    w_enq_hit = '0;
    for (int j = 0; j < WK_W; j++) begin
      if (wk_en[j]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wk_preg[j*PREG_W +: PREG_W] == r_src0[i]) w_hit0[i] = 1'b1;
          if (wk_preg[j*PREG_W +: PREG_W] == r_src1[i]) w_hit1[i] = 1'b1;
        end
        for (int e = 0; e < ENQ_W*2; e++) begin
          if (wk_preg[j*PREG_W +: PREG_W] == enq_src[e*PREG_W +: PREG_W]) w_enq_hit[e] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_flush[i] = redirect & r_valid[i] & rob_younger(r_rob[i], redirect_idx);
    end
  end

`ifdef IQ_BYPASS_WAKEUP_EN
  assign w_rdy0_eff = r_rdy0 | w_hit0;
  assign w_rdy1_eff = r_rdy1 | w_hit1;
`else
  assign w_rdy0_eff = r_rdy0;
  assign w_rdy1_eff = r_rdy1;
`endif

  assign w_cand = r_valid & w_rdy0_eff & w_rdy1_eff & ~w_flush;

  // Cascaded oldest-first select: an entry wins a port when no remaining candidate is older than it.
  always_comb begin
    logic [DEPTH-1:0] w_rem;
    logic             w_blocked;
    w_rem     = w_cand;
    w_blocked = 1'b0;
    for (int k = 0; k < ISS_W; k++) begin
      w_sel[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        w_blocked = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          if (w_rem[j] && r_age[j][i]) w_blocked = 1'b1;
        end
        if (w_rem[i] && !w_blocked) w_sel[k][i] = 1'b1;
      end
      w_rem = w_rem & ~w_sel[k];
    end
  end

  // One-hot selection drives the issue payload muxes
  always_comb begin
    iss_valid = '0;
    iss_data  = '0;
    iss_rob   = '0;
    iss_src   = '0;
    w_deq     = '0;
    for (int k = 0; k < ISS_W; k++) begin
      iss_valid[k] = |w_sel[k];
      if (iss_ready[k]) w_deq = w_deq | w_sel[k];
      for (int i = 0; i < DEPTH; i++) begin
        if (w_sel[k][i]) begin
          iss_data[k*DATA_W +: DATA_W]         = r_data[i];
          iss_rob[k*(ROB_W+1) +: (ROB_W+1)]    = r_rob[i];
          iss_src[(2*k)*PREG_W +: PREG_W]      = r_src0[i];
          iss_src[(2*k+1)*PREG_W +: PREG_W]    = r_src1[i];
        end
      end
    end
  end

  assign enq_ready = (r_free_cnt >= CNT_W'(ENQ_W)) & ~redirect;
  assign free_cnt  = r_free_cnt;

  // Allocation: each granted port takes the lowest still-free index, port 0 first.
  // Slots freed by issue/flush this cycle are not reused until next cycle.
  always_comb begin
    logic [DEPTH-1:0] w_avail;
    logic             w_found;
    w_avail   = ~r_valid;
    w_found   = 1'b0;
    w_wr_mask = '0;
    for (int p = 0; p < ENQ_W; p++) begin
      w_wr_vld[p] = 1'b0;
      w_wr_idx[p] = '0;
      w_found     = 1'b0;
      if (enq_en[p] && enq_ready) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_avail[i] && !w_found) begin
            w_found     = 1'b1;
            w_wr_idx[p] = IDX_W'(i);
          end
        end
      end
      if (w_found) begin
        w_wr_vld[p]           = 1'b1;
        w_avail[w_wr_idx[p]]  = 1'b0;
        w_wr_mask[w_wr_idx[p]] = 1'b1;
      end
    end
  end

  // New entry: younger than every resident entry and than lower-port writes of the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_age_nxt[i] = r_age[i];
    for (int p = 0; p < ENQ_W; p++) begin
      if (w_wr_vld[p]) begin
        w_age_nxt[w_wr_idx[p]] = '0;
        for (int j = 0; j < DEPTH; j++) w_age_nxt[j][w_wr_idx[p]] = r_valid[j];
        for (int q = 0; q < p; q++) begin
          if (w_wr_vld[q]) w_age_nxt[w_wr_idx[q]][w_wr_idx[p]] = 1'b1;
        end
      end
    end
  end

  assign w_valid_nxt = (r_valid & ~w_deq & ~w_flush) | w_wr_mask;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DEPTH; i++) w_pop = w_pop + CNT_W'(w_valid_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_rdy0     <= '0;
      r_rdy1     <= '0;
      r_free_cnt <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_free_cnt <= CNT_W'(DEPTH) - w_pop;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= w_age_nxt[i];
      r_rdy0 <= r_rdy0 | w_hit0;
      r_rdy1 <= r_rdy1 | w_hit1;
      for (int p = 0; p < ENQ_W; p++) begin
        if (w_wr_vld[p]) begin
          r_rdy0[w_wr_idx[p]] <= enq_src_rdy[2*p]   | w_enq_hit[2*p];
          r_rdy1[w_wr_idx[p]] <= enq_src_rdy[2*p+1] | w_enq_hit[2*p+1];
        end
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind r_valid
  always_ff @(posedge clk) begin
    for (int p = 0; p < ENQ_W; p++) begin
      if (w_wr_vld[p]) begin
        r_data[w_wr_idx[p]] <= enq_data[p*DATA_W +: DATA_W];
        r_rob[w_wr_idx[p]]  <= enq_rob[p*(ROB_W+1) +: (ROB_W+1)];
        r_src0[w_wr_idx[p]] <= enq_src[(2*p)*PREG_W +: PREG_W];
        r_src1[w_wr_idx[p]] <= enq_src[(2*p+1)*PREG_W +: PREG_W];
      end
    end
  end

endmodule

// File: tb/tb_age_issue_queue.sv
// Bench for age_issue_queue: directed scenarios with literal expectations plus randomized traffic,
// all checked each cycle against an entry-list model ordered by dispatch stamp.
module tb_age_issue_queue;
  localparam int DEPTH = 16;
  localparam int ENQ_W = 2;
  localparam int ISS_W = 2;
  localparam int WK_W  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   enq_en;
  logic [127:0] enq_data;
  logic [13:0]  enq_rob;
  logic [27:0]  enq_src;
  logic [3:0]   enq_src_rdy;
  logic         enq_ready;
  logic [4:0]   free_cnt;
  logic [3:0]   wk_en;
  logic [27:0]  wk_preg;
  logic [1:0]   iss_valid;
  logic [1:0]   iss_ready;
  logic [127:0] iss_data;
  logic [13:0]  iss_rob;
  logic [27:0]  iss_src;
  logic         redirect;
  logic [6:0]   redirect_idx;

  age_issue_queue dut (
    .clk(clk), .rst(rst),
    .enq_en(enq_en), .enq_data(enq_data), .enq_rob(enq_rob), .enq_src(enq_src),
    .enq_src_rdy(enq_src_rdy), .enq_ready(enq_ready), .free_cnt(free_cnt),
    .wk_en(wk_en), .wk_preg(wk_preg),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data),
    .iss_rob(iss_rob), .iss_src(iss_src),
    .redirect(redirect), .redirect_idx(redirect_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [6:0]  rob;
    logic [6:0]  s0;
    logic [6:0]  s1;
    logic        r0;
    logic        r1;
    logic [31:0] stamp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] stamp_ctr = 0;
  int          total = 0;
  int          bad = 0;
  logic [63:0] uid = 64'h1000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic wk_hit(input logic [6:0] t);
    for (int j = 0; j < WK_W; j++)
      if (wk_en[j] && wk_preg[j*7 +: 7] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Program order around the ROB wrap
  function automatic logic younger(input logic [6:0] a, input logic [6:0] b);
    if (a[6] == b[6]) return a[5:0] > b[5:0];
    return a[5:0] < b[5:0];
  endfunction

  function automatic logic is_cand(input ent_t e);
    logic r0, r1;
    r0 = e.r0;
    r1 = e.r1;
`ifdef IQ_BYPASS_WAKEUP_EN
    r0 = r0 | wk_hit(e.s0);
    r1 = r1 | wk_hit(e.s1);
`endif
    return r0 && r1 && !(redirect && younger(e.rob, redirect_idx));
  endfunction

  task automatic set_idle();
    enq_en = '0; enq_data = '0; enq_rob = '0; enq_src = '0; enq_src_rdy = '0;
    wk_en = '0; wk_preg = '0; iss_ready = '0; redirect = 1'b0; redirect_idx = '0;
  endtask

  task automatic enq_set(input int p, input logic [63:0] d, input logic [6:0] rob,
                         input logic [6:0] s0, input logic [6:0] s1, input logic r0, input logic r1);
    enq_en[p]             = 1'b1;
    enq_data[p*64 +: 64]  = d;
    enq_rob[p*7 +: 7]     = rob;
    enq_src[(2*p)*7 +: 7] = s0;
    enq_src[(2*p+1)*7 +: 7] = s1;
    enq_src_rdy[2*p]      = r0;
    enq_src_rdy[2*p+1]    = r1;
  endtask

  // Called at negedge with inputs driven: check every output against the model, then advance the model.
  task automatic step();
    int   sel[ISS_W];
    bit   exp_rdy, used, iss, fl;
    ent_t nq[$];
    ent_t e;
    #1;
    exp_rdy = ((DEPTH - mq.size()) >= ENQ_W) && !redirect;
    chk("enq_ready", 64'(enq_ready), 64'(exp_rdy));
    chk("free_cnt", 64'(free_cnt), 64'(DEPTH - mq.size()));
    for (int k = 0; k < ISS_W; k++) begin
      sel[k] = -1;
      for (int i = 0; i < mq.size(); i++) begin
        used = 1'b0;
        for (int m = 0; m < k; m++) if (sel[m] == i) used = 1'b1;
        if (!used && is_cand(mq[i]) && (sel[k] < 0 || mq[i].stamp < mq[sel[k]].stamp)) sel[k] = i;
      end
      chk($sformatf("iss_valid%0d", k), 64'(iss_valid[k]), 64'(sel[k] >= 0));
      if (sel[k] >= 0) begin
        chk($sformatf("iss_data%0d", k), iss_data[k*64 +: 64], mq[sel[k]].data);
        chk($sformatf("iss_rob%0d", k), 64'(iss_rob[k*7 +: 7]), 64'(mq[sel[k]].rob));
        chk($sformatf("iss_src0_%0d", k), 64'(iss_src[(2*k)*7 +: 7]), 64'(mq[sel[k]].s0));
        chk($sformatf("iss_src1_%0d", k), 64'(iss_src[(2*k+1)*7 +: 7]), 64'(mq[sel[k]].s1));
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      iss = 1'b0;
      for (int k = 0; k < ISS_W; k++) if (sel[k] == i && iss_ready[k]) iss = 1'b1;
      fl = redirect && younger(mq[i].rob, redirect_idx);
      if (!iss && !fl) begin
        e = mq[i];
        e.r0 = e.r0 | wk_hit(e.s0);
        e.r1 = e.r1 | wk_hit(e.s1);
        nq.push_back(e);
      end
    end
    if (exp_rdy) begin
      for (int p = 0; p < ENQ_W; p++) begin
        if (enq_en[p]) begin
          e.data  = enq_data[p*64 +: 64];
          e.rob   = enq_rob[p*7 +: 7];
          e.s0    = enq_src[(2*p)*7 +: 7];
          e.s1    = enq_src[(2*p+1)*7 +: 7];
          e.r0    = enq_src_rdy[2*p] | wk_hit(e.s0);
          e.r1    = enq_src_rdy[2*p+1] | wk_hit(e.s1);
          e.stamp = stamp_ctr;
          stamp_ctr++;
          nq.push_back(e);
        end
      end
    end
    @(posedge clk);
    mq = nq;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse, checked while still asserted
  task automatic do_reset(input string nm);
    rst = 1'b1;
    set_idle();
    #1;
    chk({nm, "_free_cnt"}, 64'(free_cnt), 64'd16);
    chk({nm, "_iss_valid"}, 64'(iss_valid), 64'd0);
    chk({nm, "_enq_ready"}, 64'(enq_ready), 64'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    do_reset("reset");

    // Two ready uops -> both issue next cycle, port 0 holds the older one
    set_idle(); iss_ready = 2'b11;
    enq_set(0, 64'hA0, 7'd1, 7'd1, 7'd2, 1'b1, 1'b1);
    enq_set(1, 64'hA1, 7'd2, 7'd3, 7'd4, 1'b1, 1'b1);
    step();
    set_idle(); iss_ready = 2'b11; #1;
    chk("pair_valid", 64'(iss_valid), 64'b11);
    chk("pair_p0_data", iss_data[63:0], 64'hA0);
    step();
    do_reset("rst_a");

    // Fill with tag 9 pending, then wake it
    for (int c = 0; c < 8; c++) begin
      set_idle(); iss_ready = 2'b11;
      enq_set(0, uid, 7'(2*c), 7'd9, 7'd1, 1'b0, 1'b1); uid++;
      enq_set(1, uid, 7'(2*c+1), 7'd9, 7'd1, 1'b0, 1'b1); uid++;
      step();
    end
    set_idle(); iss_ready = 2'b11; #1;
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    chk("full_free_cnt", 64'(free_cnt), 64'd0);
    wk_en = 4'b0001; wk_preg[6:0] = 7'd9; #1;
`ifdef IQ_BYPASS_WAKEUP_EN
    chk("wake_same_cycle", 64'(iss_valid), 64'b11);
`else
    chk("wake_same_cycle", 64'(iss_valid), 64'b00);
`endif
    step();
    set_idle(); iss_ready = 2'b11; #1;
    chk("wake_next_cycle", 64'(iss_valid), 64'b11);
    step();
    set_idle(); #1;
`ifdef IQ_BYPASS_WAKEUP_EN
    chk("wake_free_cnt", 64'(free_cnt), 64'd4);
`else
    chk("wake_free_cnt", 64'(free_cnt), 64'd2);
`endif
    step();
    do_reset("rst_b");

    // rob 3,4,5 all ready, only port 0 accepts
    set_idle();
    enq_set(0, 64'hB3, 7'd3, 7'd1, 7'd1, 1'b1, 1'b1);
    enq_set(1, 64'hB4, 7'd4, 7'd1, 7'd1, 1'b1, 1'b1);
    step();
    set_idle();
    enq_set(0, 64'hB5, 7'd5, 7'd1, 7'd1, 1'b1, 1'b1);
    step();
    set_idle(); iss_ready = 2'b01; #1;
    chk("part_valid", 64'(iss_valid), 64'b11);
    chk("part_p0_rob", 64'(iss_rob[6:0]), 64'd3);
    step();
    set_idle(); iss_ready = 2'b01; #1;
    chk("part_next_p0_rob", 64'(iss_rob[6:0]), 64'd4);
    step();
    do_reset("rst_c");

    // Wrap-aware flush: rob 0,1 with flag 1 are younger than 63 flag 0
    set_idle();
    enq_set(0, 64'hC0, 7'h40, 7'd1, 7'd1, 1'b1, 1'b1);
    enq_set(1, 64'hC1, 7'h41, 7'd1, 7'd1, 1'b1, 1'b1);
    step();
    set_idle();
    enq_set(0, 64'hC2, 7'd62, 7'd1, 7'd1, 1'b1, 1'b1);
    enq_set(1, 64'hC3, 7'd63, 7'd1, 7'd1, 1'b1, 1'b1);
    step();
    set_idle(); redirect = 1'b1; redirect_idx = 7'd63;
    enq_set(0, 64'hCF, 7'd10, 7'd1, 7'd1, 1'b1, 1'b1);
    #1;
    chk("flush_enq_ready", 64'(enq_ready), 64'd0);
    chk("flush_p0_rob", 64'(iss_rob[6:0]), 64'd62);
    chk("flush_p1_rob", 64'(iss_rob[13:7]), 64'd63);
    chk("flush_free_before", 64'(free_cnt), 64'd12);
    step();
    set_idle(); #1;
    chk("flush_free_after", 64'(free_cnt), 64'd14);
    step();
    do_reset("rst_d");

    // Wakeup coincident with dispatch
    set_idle();
    enq_set(0, 64'hD0, 7'd7, 7'd12, 7'd3, 1'b0, 1'b1);
    wk_en = 4'b0001; wk_preg[6:0] = 7'd12;
    step();
    set_idle(); #1;
    chk("enq_wake_valid", 64'(iss_valid), 64'b01);
    chk("enq_wake_data", iss_data[63:0], 64'hD0);
    step();
    do_reset("rst_e");

    // Reset with 5 resident entries
    for (int c = 0; c < 3; c++) begin
      set_idle();
      enq_set(0, uid, 7'(c), 7'd1, 7'd1, 1'b1, 1'b1); uid++;
      if (c < 2) begin enq_set(1, uid, 7'(c+8), 7'd1, 7'd1, 1'b1, 1'b1); uid++; end
      step();
    end
    set_idle(); #1;
    chk("pre_rst_valid", 64'(iss_valid), 64'b11);
    chk("pre_rst_free", 64'(free_cnt), 64'd11);
    do_reset("mid_rst");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      for (int p = 0; p < ENQ_W; p++) begin
        if ($urandom_range(0, 3) != 0)
          enq_set(p, uid, 7'($urandom), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                  1'($urandom), 1'($urandom));
        uid++;
      end
      iss_ready = 2'($urandom);
      for (int j = 0; j < WK_W; j++) begin
        wk_en[j] = ($urandom_range(0, 2) == 0);
        wk_preg[j*7 +: 7] = 7'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) begin
        redirect = 1'b1;
        redirect_idx = 7'($urandom);
      end
      step();
      if (c == 1500) do_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
